aes_block_packer: RTL and testbench

- Upstream feeder for the combinational AES encrypt core.
- Accepts a narrow word stream over a valid/ready handshake and assembles words into 128-bit plaintext blocks.
- Presents each assembled block, registered and held stable, on a valid/ready block interface.
- Double-buffered (assembly register plus output register), so a full word rate is sustained while the sink accepts blocks.

---
 rtl/aes_block_packer_pkg.sv | 27 ++
 rtl/aes_block_packer_if.sv | 37 +++
 rtl/aes_block_packer_block_reg.sv | 62 ++++++
 rtl/aes_block_packer.sv | 106 ++++++++++
 tb/tb_aes_block_packer.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_block_packer_pkg.sv
// -----------------------------------------------------------------------------
// aes_block_packer_pkg
// Shared constants and helpers for the AES plaintext/ciphertext block path.
//   AES_BLOCK_W    : width of one AES block (128 bits)
//   DEFAULT_WORD_W : default width of the narrow word stream
//   aes_block_t    : one 128-bit block
//   slot_offset()  : bit distance of a word slot below the block MSB
//   pad_fill()     : a block made of one pad byte replicated
// -----------------------------------------------------------------------------
package aes_block_packer_pkg;

  localparam int AES_BLOCK_W    = 128;
  localparam int DEFAULT_WORD_W = 32;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  // Slot 0 sits at the MSB end, so slot n starts word_w*n bits below the MSB.
  function automatic int unsigned slot_offset(input int unsigned word_w,
                                              input int unsigned slot);
    return word_w * slot;
  endfunction

  function automatic aes_block_t pad_fill(input logic [7:0] pad_byte);
    return {(AES_BLOCK_W/8){pad_byte}};
  endfunction

endpackage

// File: rtl/aes_block_packer_if.sv
// -----------------------------------------------------------------------------
// aes_block_packer_if
// Word-stream input and block output handshakes of the packer.
//   s_data/s_valid/s_last -> s_ready   : narrow word stream (valid/ready)
//   blk_data/blk_valid/blk_last/blk_nwords -> blk_ready : 128-bit block stream
// Modports:
//   slave  : the packer (consumes words, produces blocks)
//   master : the environment (produces words, consumes blocks)
// -----------------------------------------------------------------------------
interface aes_block_packer_if #(
  parameter int WORD_W = aes_block_packer_pkg::DEFAULT_WORD_W
);

  localparam int WPB  = aes_block_packer_pkg::AES_BLOCK_W / WORD_W;
  localparam int NW_W = $clog2(WPB + 1);

  logic [WORD_W-1:0]                          s_data;
  logic                                       s_valid;
  logic                                       s_last;
  logic                                       s_ready;
  logic [aes_block_packer_pkg::AES_BLOCK_W-1:0] blk_data;
  logic                                       blk_valid;
  logic                                       blk_last;
  logic [NW_W-1:0]                            blk_nwords;
  logic                                       blk_ready;

  modport slave (
    input  s_data, s_valid, s_last, blk_ready,
    output s_ready, blk_data, blk_valid, blk_last, blk_nwords
  );

  modport master (
    output s_data, s_valid, s_last, blk_ready,
    input  s_ready, blk_data, blk_valid, blk_last, blk_nwords
  );

endinterface

// File: rtl/aes_block_packer_block_reg.sv
// -----------------------------------------------------------------------------
// aes_block_reg
// One valid/ready register stage for a 128-bit block with last/nwords
// sideband. Contents are held stable while o_valid && !i_ready.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_load    : load i_data/i_last/i_nwords this edge (only when o_free)
//   i_ready   : downstream accepts the presented block
//   o_free    : stage can take a block this edge (empty, or draining now)
//   o_valid, o_data, o_last, o_nwords : presented block
// -----------------------------------------------------------------------------
module aes_block_reg
  import aes_block_packer_pkg::*;
#(
  parameter int NW_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  aes_block_t      i_data,
  input  logic            i_last,
  input  logic [NW_W-1:0] i_nwords,
  input  logic            i_ready,
  output logic            o_free,
  output logic            o_valid,
  output aes_block_t      o_data,
  output logic            o_last,
  output logic [NW_W-1:0] o_nwords
);

  logic            r_valid;
  aes_block_t      r_data;
  logic            r_last;
  logic [NW_W-1:0] r_nwords;

  // Free in the same cycle the current block drains: gives back-to-back blocks.
  assign o_free = !r_valid || i_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_last   <= 1'b0;
      r_nwords <= '0;
    end else if (i_load) begin
      r_valid  <= 1'b1;
      r_data   <= i_data;
      r_last   <= i_last;
      r_nwords <= i_nwords;
    end else if (i_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign o_valid  = r_valid;
  assign o_data   = r_data;
  assign o_last   = r_last;
  assign o_nwords = r_nwords;

endmodule

// File: rtl/aes_block_packer.sv
// -----------------------------------------------------------------------------
// aes_block_packer
// Assembles a WORD_W-bit word stream into 128-bit AES plaintext blocks.
// First word lands in bits [127 -: WORD_W]. A short block (closed by s_last)
// keeps PAD_BYTE in its unwritten slots. Assembly register plus output
// register give a full word rate while the sink keeps accepting blocks.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : aes_block_packer_if.slave (word stream in, block stream out)
// -----------------------------------------------------------------------------
module aes_block_packer
  import aes_block_packer_pkg::*;
#(
  parameter int         WORD_W   = DEFAULT_WORD_W,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  aes_block_packer_if.slave   bus
);

  localparam int              WPB        = AES_BLOCK_W / WORD_W;
  localparam int              NW_W       = $clog2(WPB + 1);
  localparam logic [NW_W-1:0] LAST_SLOT  = NW_W'(WPB - 1);
  localparam aes_block_t      PAD_BLOCK  = pad_fill(PAD_BYTE);
  localparam aes_block_t      SLOT0_MASK = {{WORD_W{1'b1}}, {(AES_BLOCK_W-WORD_W){1'b0}}};

  logic [NW_W-1:0] r_cnt;
  aes_block_t      r_asm;
  logic            r_full;         // completed block waiting for the output stage
  logic            r_pend_last;
  logic [NW_W-1:0] r_pend_nwords;

  logic            w_accept;
  logic            w_done;
  logic            w_free;
  logic            w_load;
  int unsigned     w_shift;
  aes_block_t      w_asm_next;
  aes_block_t      w_out_data;
  logic            w_out_last;
  logic [NW_W-1:0] w_out_nwords;

  assign bus.s_ready = !r_full;

  // NOTE: every signal driven here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    w_accept     = bus.s_valid && !r_full;
    w_done       = w_accept && (bus.s_last || (r_cnt == LAST_SLOT));
    w_shift      = slot_offset(WORD_W, 32'(r_cnt));
    // Merge the incoming word into its slot by shifting a slot-0 mask/word.
    w_asm_next   = (r_asm & ~(SLOT0_MASK >> w_shift))
                 | ({bus.s_data, {(AES_BLOCK_W-WORD_W){1'b0}}} >> w_shift);
    // A pending block always has priority: s_ready is low while it waits.
    w_load       = w_free && (r_full || w_done);
    w_out_data   = r_full ? r_asm         : w_asm_next;
    w_out_last   = r_full ? r_pend_last   : bus.s_last;
    w_out_nwords = r_full ? r_pend_nwords : r_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_asm         <= PAD_BLOCK;
      r_full        <= 1'b0;
      r_pend_last   <= 1'b0;
      r_pend_nwords <= '0;
    end else if (r_full) begin
      if (w_free) begin
        r_full <= 1'b0;
        r_asm  <= PAD_BLOCK;
      end
    end else if (w_done) begin
      r_cnt         <= '0;
      r_pend_last   <= bus.s_last;
      r_pend_nwords <= r_cnt + 1'b1;
      if (w_free) begin
        r_asm  <= PAD_BLOCK;
      end else begin
        // Output busy: park the finished block in the assembly register.
        r_asm  <= w_asm_next;
        r_full <= 1'b1;
      end
    end else if (w_accept) begin
      r_asm <= w_asm_next;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  aes_block_reg #(.NW_W(NW_W)) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_data   (w_out_data),
    .i_last   (w_out_last),
    .i_nwords (w_out_nwords),
    .i_ready  (bus.blk_ready),
    .o_free   (w_free),
    .o_valid  (bus.blk_valid),
    .o_data   (bus.blk_data),
    .o_last   (bus.blk_last),
    .o_nwords (bus.blk_nwords)
  );

endmodule

// File: tb/tb_aes_block_packer.sv
// -----------------------------------------------------------------------------
// tb_aes_block_packer
// Self-checking bench: 32-bit/PAD 00 instance for the main scenarios and an
// 8-bit/PAD FF instance for byte mode. A negedge monitor builds expected
// blocks from accepted words by shift-and-pad arithmetic.
// -----------------------------------------------------------------------------
module tb_aes_block_packer;
  import aes_block_packer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes_block_packer_if #(.WORD_W(32)) bus32 ();
  aes_block_packer_if #(.WORD_W(8))  bus8 ();

  aes_block_packer #(.WORD_W(32), .PAD_BYTE(8'h00)) dut (
    .clk (clk), .rst (rst), .bus (bus32)
  );
  aes_block_packer #(.WORD_W(8), .PAD_BYTE(8'hFF)) dut8 (
    .clk (clk), .rst (rst), .bus (bus8)
  );

  typedef struct packed {
    logic [127:0] data;
    logic         last;
    logic [2:0]   nwords;
  } blk_t;

  localparam logic [7:0] PAD32 = 8'h00;

  int   checks   = 0;
  int   failures = 0;
  blk_t exp_q[$];
  blk_t got_q[$];
  logic [127:0] m_data = '0;
  int   m_n = 0;

  // Reference model: a block is the accepted words concatenated MSB-first,
  // closed after 4 words or on s_last, then shifted left with pad words.
  always @(negedge clk) begin
    if (rst) begin
      m_data = '0;
      m_n    = 0;
    end else begin
      if (bus32.s_valid && bus32.s_ready) begin
        m_data = (m_data << 32) | {96'h0, bus32.s_data};
        m_n++;
        if (bus32.s_last || m_n == 4) begin
          for (int k = m_n; k < 4; k++) m_data = (m_data << 32) | {96'h0, {4{PAD32}}};
          exp_q.push_back('{data: m_data, last: bus32.s_last, nwords: 3'(m_n)});
          m_data = '0;
          m_n    = 0;
        end
      end
      if (bus32.blk_valid && bus32.blk_ready)
        got_q.push_back('{data: bus32.blk_data, last: bus32.blk_last, nwords: bus32.blk_nwords});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle32();
    bus32.s_valid = 1'b0;
    bus32.s_last  = 1'b0;
  endtask

  // Holds the word until accepted; returns 1 time unit after the accepting edge.
  task automatic send32(input logic [31:0] d, input logic l);
    logic rdy;
    int   n = 0;
    bus32.s_valid = 1'b1;
    bus32.s_data  = d;
    bus32.s_last  = l;
    forever begin
      @(negedge clk);
      rdy = bus32.s_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 50) begin
        checks++; failures++;
        $display("FAIL send32_timeout word=%h never accepted", d);
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus32.s_valid = 0; bus32.s_last = 0; bus32.s_data = '0; bus32.blk_ready = 0;
    bus8.s_valid  = 0; bus8.s_last  = 0; bus8.s_data  = '0; bus8.blk_ready  = 0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus32.s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", bus32.s_ready); end
    checks++; if (bus32.blk_valid !== 1'b0) begin failures++; $display("FAIL reset_blk_valid got=%b exp=0", bus32.blk_valid); end
    checks++; if (bus32.blk_last !== 1'b0) begin failures++; $display("FAIL reset_blk_last got=%b exp=0", bus32.blk_last); end
    checks++; if (bus32.blk_nwords !== 3'd0) begin failures++; $display("FAIL reset_blk_nwords got=%0d exp=0", bus32.blk_nwords); end
    checks++; if (bus32.blk_data !== 128'h0) begin failures++; $display("FAIL reset_blk_data got=%h exp=0", bus32.blk_data); end
    checks++; if (bus8.s_ready !== 1'b1 || bus8.blk_valid !== 1'b0) begin failures++; $display("FAIL reset_byte_dut got ready=%b valid=%b exp 1/0", bus8.s_ready, bus8.blk_valid); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic_block();
    bus32.blk_ready = 1'b1;
    send32(32'h00112233, 0);
    send32(32'h44556677, 0);
    send32(32'h8899AABB, 0);
    checks++; if (bus32.blk_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", bus32.blk_valid); end
    send32(32'hCCDDEEFF, 0);
    idle32();
    @(negedge clk);
    checks++; if (bus32.blk_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus32.blk_valid); end
    checks++; if (bus32.blk_data !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin failures++; $display("FAIL basic_data got=%h exp=00112233445566778899aabbccddeeff", bus32.blk_data); end
    checks++; if (bus32.blk_last !== 1'b0 || bus32.blk_nwords !== 3'd4) begin failures++; $display("FAIL basic_side got last=%b nwords=%0d exp 0/4", bus32.blk_last, bus32.blk_nwords); end
    tick();
    checks++; if (bus32.blk_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", bus32.blk_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [12];
    int          vcyc[$];
    int          drops = 0;
    got_q.delete();
    bus32.blk_ready = 1'b1;
    for (int i = 0; i < 12; i++) w[i] = $urandom;
    for (int i = 0; i < 12; i++) begin
      bus32.s_valid = 1'b1; bus32.s_data = w[i]; bus32.s_last = 1'b0;
      @(negedge clk);
      if (bus32.s_ready !== 1'b1) drops++;
      if (bus32.blk_valid === 1'b1) vcyc.push_back(i);
      tick();
    end
    idle32();
    @(negedge clk);
    if (bus32.blk_valid === 1'b1) vcyc.push_back(12);
    tick();
    checks++; if (drops != 0) begin failures++; $display("FAIL b2b_s_ready_drops got=%0d exp=0", drops); end
    checks++; if (vcyc.size() != 3 || vcyc[0] != 4 || vcyc[1] != 8 || vcyc[2] != 12)
      begin failures++; $display("FAIL b2b_valid_cycles got=%p exp='{4,8,12}", vcyc); end
    checks++; if (got_q.size() != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", got_q.size()); end
    for (int b = 0; b < 3 && b < got_q.size(); b++) begin
      checks++;
      if (got_q[b].data !== {w[4*b], w[4*b+1], w[4*b+2], w[4*b+3]} || got_q[b].nwords !== 3'd4 || got_q[b].last !== 1'b0) begin
        failures++;
        $display("FAIL b2b_block%0d got=%h exp=%h", b, got_q[b].data, {w[4*b], w[4*b+1], w[4*b+2], w[4*b+3]});
      end
    end
  endtask

  task automatic test_short_blocks();
    logic [31:0] a, b, c, d;
    bus32.blk_ready = 1'b1;
    send32(32'hA0A1A2A3, 0);
    // s_last without s_valid must not close the block.
    bus32.s_valid = 1'b0; bus32.s_last = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++; if (bus32.blk_valid !== 1'b0) begin failures++; $display("FAIL stray_last_valid got=%b exp=0", bus32.blk_valid); end
      tick();
    end
    send32(32'hB0B1B2B3, 1);
    idle32();
    @(negedge clk);
    checks++; if (bus32.blk_data !== 128'hA0A1A2A3_B0B1B2B3_00000000_00000000) begin failures++; $display("FAIL short_data got=%h exp=a0a1a2a3b0b1b2b30000000000000000", bus32.blk_data); end
    checks++; if (bus32.blk_valid !== 1'b1 || bus32.blk_last !== 1'b1 || bus32.blk_nwords !== 3'd2) begin failures++; $display("FAIL short_side got v=%b last=%b nwords=%0d exp 1/1/2", bus32.blk_valid, bus32.blk_last, bus32.blk_nwords); end
    tick();
    // s_last on the final slot: full block, no padding.
    a = $urandom; b = $urandom; c = $urandom; d = $urandom;
    send32(a, 0); send32(b, 0); send32(c, 0); send32(d, 1);
    idle32();
    @(negedge clk);
    checks++; if (bus32.blk_data !== {a, b, c, d} || bus32.blk_last !== 1'b1 || bus32.blk_nwords !== 3'd4) begin failures++; $display("FAIL full_last got=%h last=%b nwords=%0d exp=%h 1 4", bus32.blk_data, bus32.blk_last, bus32.blk_nwords, {a, b, c, d}); end
    tick();
    // s_last on the first slot: one-word block.
    a = $urandom;
    send32(a, 1);
    idle32();
    @(negedge clk);
    checks++; if (bus32.blk_data !== {a, 96'h0} || bus32.blk_last !== 1'b1 || bus32.blk_nwords !== 3'd1) begin failures++; $display("FAIL one_word got=%h nwords=%0d exp=%h 1", bus32.blk_data, bus32.blk_nwords, {a, 96'h0}); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] w [8];
    logic [127:0] b1, b2;
    int unstable = 0;
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    b1 = {w[0], w[1], w[2], w[3]};
    b2 = {w[4], w[5], w[6], w[7]};
    bus32.blk_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send32(w[i], 0);
      if (i >= 3 && (bus32.blk_valid !== 1'b1 || bus32.blk_data !== b1 || bus32.blk_nwords !== 3'd4)) unstable++;
    end
    idle32();
    checks++; if (unstable != 0) begin failures++; $display("FAIL bp_hold_first got=%0d unstable cycles exp=0", unstable); end
    checks++; if (bus32.s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready_drop got=%b exp=0", bus32.s_ready); end
    tick(); tick();
    checks++; if (bus32.s_ready !== 1'b0 || bus32.blk_data !== b1) begin failures++; $display("FAIL bp_still_held got ready=%b data=%h exp 0 %h", bus32.s_ready, bus32.blk_data, b1); end
    bus32.blk_ready = 1'b1;
    tick();
    bus32.blk_ready = 1'b0;
    checks++; if (bus32.blk_valid !== 1'b1 || bus32.blk_data !== b2) begin failures++; $display("FAIL bp_second got v=%b data=%h exp 1 %h", bus32.blk_valid, bus32.blk_data, b2); end
    checks++; if (bus32.s_ready !== 1'b1) begin failures++; $display("FAIL bp_s_ready_back got=%b exp=1", bus32.s_ready); end
    bus32.blk_ready = 1'b1;
    tick();
    checks++; if (bus32.blk_valid !== 1'b0) begin failures++; $display("FAIL bp_final_drain got=%b exp=0", bus32.blk_valid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w [4];
    int seen = 0;
    bus32.blk_ready = 1'b0;
    for (int i = 0; i < 6; i++) send32($urandom, 0);
    idle32();
    #2 rst = 1'b1;
    #1;
    checks++; if (bus32.blk_valid !== 1'b0 || bus32.s_ready !== 1'b1) begin failures++; $display("FAIL rstmid_async got v=%b ready=%b exp 0/1", bus32.blk_valid, bus32.s_ready); end
    tick(); tick();
    rst = 1'b0;
    bus32.blk_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus32.blk_valid !== 1'b0) seen++;
      tick();
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rstmid_spurious got=%0d valid cycles exp=0", seen); end
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      send32(w[i], 0);
    end
    idle32();
    checks++; if (bus32.blk_valid !== 1'b1 || bus32.blk_data !== {w[0], w[1], w[2], w[3]} || bus32.blk_nwords !== 3'd4 || bus32.blk_last !== 1'b0)
      begin failures++; $display("FAIL rstmid_new_block got v=%b data=%h nwords=%0d exp 1 %h 4", bus32.blk_valid, bus32.blk_data, bus32.blk_nwords, {w[0], w[1], w[2], w[3]}); end
    tick();
  endtask

  task automatic test_byte_mode();
    logic [127:0] expb = '0;
    logic [7:0]   b;
    bus8.blk_ready = 1'b1;
    bus8.s_valid = 1'b1; bus8.s_data = 8'h5A; bus8.s_last = 1'b1;
    checks++; if (bus8.s_ready !== 1'b1) begin failures++; $display("FAIL byte_ready got=%b exp=1", bus8.s_ready); end
    tick();
    bus8.s_valid = 1'b0; bus8.s_last = 1'b0;
    checks++; if (bus8.blk_valid !== 1'b1 || bus8.blk_data !== {8'h5A, {15{8'hFF}}}) begin failures++; $display("FAIL byte_pad got v=%b data=%h exp 1 5a%s", bus8.blk_valid, bus8.blk_data, "ff x15"); end
    checks++; if (bus8.blk_nwords !== 5'd1 || bus8.blk_last !== 1'b1) begin failures++; $display("FAIL byte_side got nwords=%0d last=%b exp 1/1", bus8.blk_nwords, bus8.blk_last); end
    tick();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      expb = (expb << 8) | {120'h0, b};
      bus8.s_valid = 1'b1; bus8.s_data = b; bus8.s_last = 1'b0;
      tick();
    end
    bus8.s_valid = 1'b0;
    checks++; if (bus8.blk_valid !== 1'b1 || bus8.blk_data !== expb || bus8.blk_nwords !== 5'd16 || bus8.blk_last !== 1'b0)
      begin failures++; $display("FAIL byte_full got v=%b data=%h nwords=%0d exp 1 %h 16", bus8.blk_valid, bus8.blk_data, bus8.blk_nwords, expb); end
    tick();
  endtask

  task automatic test_random();
    logic         pv = 1'b0, pr = 1'b0;
    logic [127:0] pd = '0;
    logic [2:0]   pn = '0;
    logic         pl = 1'b0;
    int           hold_err = 0;
    exp_q.delete();
    got_q.delete();
    for (int c = 0; c < 400; c++) begin
      bus32.s_valid   = ($urandom_range(3) != 0);
      bus32.s_data    = $urandom;
      bus32.s_last    = ($urandom_range(4) == 0);
      bus32.blk_ready = ($urandom_range(2) != 0);
      @(negedge clk);
      if (pv && !pr && (bus32.blk_valid !== 1'b1 || bus32.blk_data !== pd || bus32.blk_nwords !== pn || bus32.blk_last !== pl))
        hold_err++;
      pv = bus32.blk_valid; pr = bus32.blk_ready; pd = bus32.blk_data; pn = bus32.blk_nwords; pl = bus32.blk_last;
      tick();
    end
    bus32.blk_ready = 1'b1;
    send32($urandom, 1);
    idle32();
    for (int t = 0; t < 20 && got_q.size() != exp_q.size(); t++) tick();
    tick();
    checks++; if (hold_err != 0) begin failures++; $display("FAIL random_hold got=%0d violations exp=0", hold_err); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL random_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL random_block%0d got=%h/%b/%0d exp=%h/%b/%0d", i, got_q[i].data, got_q[i].last, got_q[i].nwords, exp_q[i].data, exp_q[i].last, exp_q[i].nwords);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_block();
    test_back_to_back();
    test_short_blocks();
    test_backpressure();
    test_reset_mid();
    test_byte_mode();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
